// File: rtl/apb_pkg.sv
// Shared APB definitions: requester FSM states, response encoding and pprot default.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    typedef enum logic {
        RESP_OKAY   = 1'b0,
        RESP_SLVERR = 1'b1
    } apb_resp_e;

    localparam logic [2:0] PPROT_DEFAULT = 3'b000;

endpackage

// File: rtl/apb_if.sv
// APB bus bundle; the requester modport is the master's view of the bus.
interface apb_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0]       paddr;
    logic [2:0]                  pprot;
    logic                        psel;
    logic                        penable;
    logic                        pwrite;
    logic [DATA_WIDTH-1:0]       pwdata;
    logic [(DATA_WIDTH+7)/8-1:0] pstrb;
    logic                        pready;
    logic [DATA_WIDTH-1:0]       prdata;
    logic                        pslverr;

    modport requester (
        output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_req_master_intf.sv
// Wrapper exposing apb_req_master's APB side through an apb_if requester modport.
module apb_req_master_intf #(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32
) (
    input  logic                            pclk_i,
    input  logic                            preset_i,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic [APB_ADDR_WIDTH-1:0]       req_addr_i,
    input  logic                            req_write_i,
    input  logic [APB_DATA_WIDTH-1:0]       req_wdata_i,
    input  logic [(APB_DATA_WIDTH+7)/8-1:0] req_strb_i,
    output logic                            rsp_valid_o,
    input  logic                            rsp_ready_i,
    output logic [APB_DATA_WIDTH-1:0]       rsp_rdata_o,
    output logic                            rsp_slverr_o,
    apb_if.requester                        apb
);
    apb_req_master #(
        .APB_ADDR_WIDTH(APB_ADDR_WIDTH),
        .APB_DATA_WIDTH(APB_DATA_WIDTH)
    ) u_core (
        .pclk_i      (pclk_i),
        .preset_i    (preset_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_write_i (req_write_i),
        .req_wdata_i (req_wdata_i),
        .req_strb_i  (req_strb_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_slverr_o(rsp_slverr_o),
        .paddr_o     (apb.paddr),
        .pprot_o     (apb.pprot),
        .psel_o      (apb.psel),
        .penable_o   (apb.penable),
        .pwrite_o    (apb.pwrite),
        .pwdata_o    (apb.pwdata),
        .pstrb_o     (apb.pstrb),
        .pready_i    (apb.pready),
        .prdata_i    (apb.prdata),
        .pslverr_i   (apb.pslverr)
    );
endmodule

// File: rtl/apb_req_master.sv
// Single-outstanding APB requester: request channel -> APB transfer -> response channel.
// Define APB_REQ_MASTER_BACK2BACK_EN to allow a new request to be taken in the response cycle.
module apb_req_master
    import apb_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32
) (
    input  logic                            pclk_i,
    input  logic                            preset_i,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic [APB_ADDR_WIDTH-1:0]       req_addr_i,
    input  logic                            req_write_i,
    input  logic [APB_DATA_WIDTH-1:0]       req_wdata_i,
    input  logic [(APB_DATA_WIDTH+7)/8-1:0] req_strb_i,
    output logic                            rsp_valid_o,
    input  logic                            rsp_ready_i,
    output logic [APB_DATA_WIDTH-1:0]       rsp_rdata_o,
    output logic                            rsp_slverr_o,
    output logic [APB_ADDR_WIDTH-1:0]       paddr_o,
    output logic [2:0]                      pprot_o,
    output logic                            psel_o,
    output logic                            penable_o,
    output logic                            pwrite_o,
    output logic [APB_DATA_WIDTH-1:0]       pwdata_o,
    output logic [(APB_DATA_WIDTH+7)/8-1:0] pstrb_o,
    input  logic                            pready_i,
    input  logic [APB_DATA_WIDTH-1:0]       prdata_i,
    input  logic                            pslverr_i
);
    localparam int unsigned STRB_WIDTH = (APB_DATA_WIDTH + 7) / 8;

    apb_state_e state, state_next;
    logic req_hs, rsp_hs;

    logic [APB_ADDR_WIDTH-1:0] addr_q;
    logic                      write_q;
    logic [APB_DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0]     strb_q;
    logic [APB_DATA_WIDTH-1:0] rdata_q;
    apb_resp_e                 resp_q;

    assign req_hs = req_valid_i && req_ready_o;
    assign rsp_hs = rsp_valid_o && rsp_ready_i;

    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (req_hs) state_next = SETUP;
            SETUP:  state_next = ACCESS;
            ACCESS: if (pready_i) state_next = RESP;
            RESP: begin
                if (rsp_hs) begin
`ifdef APB_REQ_MASTER_BACK2BACK_EN
                    state_next = req_hs ? SETUP : IDLE;
`else
                    state_next = IDLE;
`endif
                end
            end
        endcase
    end

    // req_ready_o is gated by reset directly since the state alone reads IDLE while reset is held.
    always_comb begin
        req_ready_o = 1'b0;
        psel_o      = 1'b0;
        penable_o   = 1'b0;
        rsp_valid_o = 1'b0;
        case (state)
            IDLE:   req_ready_o = !preset_i;
            SETUP:  psel_o = 1'b1;
            ACCESS: begin
                psel_o    = 1'b1;
                penable_o = 1'b1;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
`ifdef APB_REQ_MASTER_BACK2BACK_EN
                req_ready_o = rsp_ready_i && !preset_i;
`endif
            end
        endcase
    end

    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            rdata_q <= '0;
            resp_q  <= RESP_OKAY;
        end else begin
            if (req_hs) begin
                addr_q  <= req_addr_i;
                write_q <= req_write_i;
                wdata_q <= req_wdata_i;
                strb_q  <= req_write_i ? req_strb_i : '0;
            end
            if (state == ACCESS && pready_i) begin
                rdata_q <= write_q ? '0 : prdata_i;
                resp_q  <= pslverr_i ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    assign paddr_o      = addr_q;
    assign pprot_o      = PPROT_DEFAULT;
    assign pwrite_o     = write_q;
    assign pwdata_o     = wdata_q;
    assign pstrb_o      = strb_q;
    assign rsp_rdata_o  = rdata_q;
    assign rsp_slverr_o = (resp_q == RESP_SLVERR);

endmodule
